// File: rtl/lib_cpu.sv
// Shared types for the 4-bit CPU: instruction encoding, loader states and
// program store geometry.
package lib_cpu;

  localparam int PROG_DEPTH = 16;
  localparam int ADDR_W     = $clog2(PROG_DEPTH);
  // One extra bit so a write pointer can hold PROG_DEPTH itself.
  localparam int PTR_W      = ADDR_W + 1;

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'h0,
    OP_MOV_AB = 4'h1,
    OP_IN_A   = 4'h2,
    OP_MOV_A  = 4'h3,
    OP_MOV_BA = 4'h4,
    OP_ADD_B  = 4'h5,
    OP_IN_B   = 4'h6,
    OP_MOV_B  = 4'h7,
    OP_OUT_B  = 4'h9,
    OP_OUT_IM = 4'hB,
    OP_JNC    = 4'hE,
    OP_JMP    = 4'hF
  } OPECODE;

  typedef struct packed {
    OPECODE     opcode;
    logic [3:0] imm;
  } INSN;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    COUNT,
    DATA,
    CHK,
    FILL,
    RUN
  } LD_STATE;

endpackage

// File: rtl/prog_ram.sv
// 16 x 8 program store: one synchronous write port, one combinational read
// port shared with the core's fetch path.
module prog_ram
  import lib_cpu::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [PROG_DEPTH];

  // Write port; the loader's CLEAR sweep gives every entry a defined value.
  // NOTE: the array is deliberately not reset so it maps onto plain RAM/LUTRAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts a framed byte stream (sync, count, data, checksum),
// writes it into the program RAM, pads unused entries and releases the core.
module prog_loader
  import lib_cpu::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] FILL_WORD = 8'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [7:0]        fetch_insn,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              load_busy,
  output logic              load_err
);

  LD_STATE          state, state_n;
  logic [PTR_W-1:0] ptr;        // CLEAR / DATA / FILL address
  logic [7:0]       frame_len;  // N of the current frame
  logic [7:0]       sum;

  logic accept, is_sync, len_ok, last_data;
  logic we;
  logic [7:0] wdata;

  assign accept    = rx_valid && rx_ready;
  assign is_sync   = accept && (rx_data == SYNC_BYTE);
  assign len_ok    = (rx_data != 8'd0) && (rx_data <= 8'(PROG_DEPTH));
  assign last_data = (({3'b000, ptr} + 8'd1) == frame_len);

  // Next-state decode.
  // NOTE: default assignment first so no path leaves state_n unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      CLEAR:     if (ptr == PTR_W'(PROG_DEPTH - 1)) state_n = IDLE;
      IDLE, RUN: if (is_sync) state_n = COUNT;
      COUNT:     if (accept) state_n = len_ok ? DATA : IDLE;
      DATA:      if (accept && last_data) state_n = CHK;
      CHK: begin
        if (accept) begin
          if (rx_data != sum)                    state_n = IDLE;
          else if (frame_len == 8'(PROG_DEPTH))  state_n = RUN;
          else                                   state_n = FILL;
        end
      end
      FILL:      if (ptr == PTR_W'(PROG_DEPTH - 1)) state_n = RUN;
      default:   state_n = CLEAR;
    endcase
  end

  // FSM state, counters, checksum and outputs registered from the next state.
  // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      ptr         <= '0;
      frame_len   <= '0;
      sum         <= '0;
      load_err    <= 1'b0;
      rx_ready    <= 1'b0;
      cpu_hold    <= 1'b1;
      cpu_restart <= 1'b0;
      load_busy   <= 1'b0;
    end else begin
      state       <= state_n;
      rx_ready    <= !(state_n inside {CLEAR, FILL});
      cpu_hold    <= (state_n != RUN);
      load_busy   <= (state_n inside {COUNT, DATA, CHK, FILL});
      cpu_restart <= (state_n == RUN) && (state != RUN);
      case (state)
        CLEAR, FILL: ptr <= ptr + PTR_W'(1);
        IDLE, RUN:   if (is_sync) load_err <= 1'b0;
        COUNT: begin
          if (accept) begin
            if (len_ok) begin
              frame_len <= rx_data;
              ptr       <= '0;
              sum       <= '0;
            end else begin
              load_err  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (accept) begin
            sum <= sum + rx_data;
            ptr <= ptr + PTR_W'(1);
          end
        end
        CHK:     if (accept && (rx_data != sum)) load_err <= 1'b1;
        default: ;
      endcase
    end
  end

  // After DATA the pointer already sits at N, so FILL continues from there.
  assign we    = (state == CLEAR) || (state == FILL) || ((state == DATA) && accept);
  assign wdata = (state == DATA) ? rx_data : FILL_WORD;

  prog_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ptr[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (fetch_addr),
    .rdata (fetch_insn)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: reset sweep, short/full loads, checksum and
// count errors, noise, backpressure, reload and mid-frame reset.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [3:0] fetch_addr = 4'h0;
  logic [7:0] fetch_insn;
  logic       cpu_hold, cpu_restart, load_busy, load_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [16];
  logic [7:0] fr [$];
  bit         gaps = 1'b0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .fetch_addr  (fetch_addr),
    .fetch_insn  (fetch_insn),
    .cpu_hold    (cpu_hold),
    .cpu_restart (cpu_restart),
    .load_busy   (load_busy),
    .load_err    (load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte transferred.
  task automatic send(input logic [7:0] b);
    int n = 0;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!rx_ready) check("send_timeout", 32'(rx_ready), 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_fr();
    foreach (fr[i]) send(fr[i]);
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 16; i++) begin
      fetch_addr = i[3:0];
      #0.1;
      check($sformatf("%s[%0d]", tag, i), 32'(fetch_insn), 32'(model[i]));
    end
    @(posedge clk); #1;
  endtask

  // Counts edges until the core is released, then checks the restart pulse.
  task automatic wait_run(input string tag, input int exp_cycles);
    int n = 0;
    while (cpu_hold && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, "_fill_cycles"}, n, exp_cycles);
    check({tag, "_restart_hi"}, 32'(cpu_restart), 1);
    @(posedge clk); #1;
    check({tag, "_restart_lo"}, 32'(cpu_restart), 0);
    check({tag, "_running"}, 32'(cpu_hold), 0);
  endtask

  task automatic check_reset_sweep(input string tag);
    check({tag, "_ready"},   32'(rx_ready), 0);
    check({tag, "_hold"},    32'(cpu_hold), 1);
    check({tag, "_restart"}, 32'(cpu_restart), 0);
    check({tag, "_busy"},    32'(load_busy), 0);
    check({tag, "_err"},     32'(load_err), 0);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      check($sformatf("%s_hold_c%0d", tag, c), 32'(cpu_hold), 1);
      check($sformatf("%s_ready_c%0d", tag, c), 32'(rx_ready), (c == 16) ? 1 : 0);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'hF0;
    check_ram({tag, "_ram"});
  endtask

  initial begin
    // Reset and CLEAR sweep.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_sweep("reset");

    // Short load: N=3.
    fr = {8'hA5, 8'h03, 8'h31, 8'h52, 8'hF0, 8'h73};
    send_fr();
    check("short_busy", 32'(load_busy), 1);
    check("short_ready_fill", 32'(rx_ready), 0);
    wait_run("short", 13);
    check("short_err", 32'(load_err), 0);
    model[0] = 8'h31; model[1] = 8'h52; model[2] = 8'hF0;
    check_ram("short_ram");

    // Reload from RUN with a bad checksum.
    send(8'hA5);
    check("reload_hold", 32'(cpu_hold), 1);
    check("reload_restart", 32'(cpu_restart), 0);
    check("reload_busy", 32'(load_busy), 1);
    fr = {8'h02, 8'h11, 8'h22, 8'h00};
    send_fr();
    check("badchk_err", 32'(load_err), 1);
    check("badchk_busy", 32'(load_busy), 0);
    check("badchk_ready", 32'(rx_ready), 1);
    repeat (3) @(posedge clk); #1;
    check("badchk_hold", 32'(cpu_hold), 1);
    model[0] = 8'h11; model[1] = 8'h22;
    check_ram("badchk_ram");
    send(8'hA5);
    check("badchk_err_clr", 32'(load_err), 0);
    fr = {8'h02, 8'h11, 8'h22, 8'h33};
    send_fr();
    wait_run("recover", 14);

    // Full load: N=16, no FILL.
    fr = {8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) fr.push_back(8'(i));
    fr.push_back(8'h78);
    send_fr();
    check("full_hold", 32'(cpu_hold), 0);
    wait_run("full", 0);
    for (int i = 0; i < 16; i++) model[i] = 8'(i);
    check_ram("full_ram");

    // Noise and invalid counts.
    send(8'h42);
    check("noise_run_hold", 32'(cpu_hold), 0);
    check("noise_run_busy", 32'(load_busy), 0);
    fr = {8'hA5, 8'h00};
    send_fr();
    check("cnt0_err", 32'(load_err), 1);
    check("cnt0_hold", 32'(cpu_hold), 1);
    check("cnt0_busy", 32'(load_busy), 0);
    send(8'h42);
    check("noise_idle_err", 32'(load_err), 1);
    check("noise_idle_busy", 32'(load_busy), 0);
    send(8'hA5);
    check("cnt17_sync_err", 32'(load_err), 0);
    send(8'h11);
    check("cnt17_err", 32'(load_err), 1);
    check("cnt17_busy", 32'(load_busy), 0);
    check_ram("badcnt_ram");

    // Backpressure: random gaps, SYNC value as data, valid held during FILL.
    gaps = 1'b1;
    fr = {8'hA5, 8'h04, 8'hA5, 8'h01, 8'h02, 8'h03, 8'hAB};
    send_fr();
    gaps = 1'b0;
    rx_data  = 8'h42;
    rx_valid = 1'b1;
    wait_run("bp", 12);
    rx_valid = 1'b0;
    check("bp_err", 32'(load_err), 0);
    model[0] = 8'hA5; model[1] = 8'h01; model[2] = 8'h02; model[3] = 8'h03;
    for (int i = 4; i < 16; i++) model[i] = 8'hF0;
    check_ram("bp_ram");

    // Reset in the middle of DATA.
    fr = {8'hA5, 8'h05, 8'h11, 8'h22};
    send_fr();
    check("middata_busy", 32'(load_busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_sweep("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and instruction store for the 4-bit CPU. Receives a framed byte stream over a valid/ready interface and writes it into the 16-entry × 8-bit program RAM. The core's fetch path reads that same RAM. The block holds the core halted while loading, verifies a checksum, pads unused entries, then releases the core with a restart pulse.

## Interface
Parameters:
- `SYNC_BYTE`, `8'hA5`: frame start marker.
- `FILL_WORD`, `8'hF0`: pad word for unloaded entries (`JMP 0`).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  incoming stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `fetch_addr`  in  4  core instruction pointer.
- `fetch_insn`  out  8  instruction at `fetch_addr`, as INSN: opcode `[7:4]`, imm `[3:0]`.
- `cpu_hold`  out  1  core must not update its registers.
- `cpu_restart`  out  1  one-cycle pulse; core resets `ip`, `a`, `b`, `out`, `cf` to 0.
- `load_busy`  out  1  frame in progress.
- `load_err`  out  1  last frame rejected; sticky.

## Operation
- Frame format: `SYNC_BYTE`, then COUNT `N`, then `N` instruction bytes, then CHK.
  - Valid COUNT values are 1..16.
  - CHK is the sum of the `N` instruction bytes, modulo 256.
- A byte transfers only on a cycle where both `rx_valid` and `rx_ready` are high.

States and transitions:
- CLEAR: entered on reset. Writes `FILL_WORD` to addresses 0..15, one per cycle. Then goes to IDLE.
- IDLE: core halted. A `SYNC_BYTE` goes to COUNT; any other byte is dropped.
- COUNT: on accept:
  - `N` in 1..16: `wr_ptr` = 0, sum = 0, go to DATA.
  - Otherwise: set `load_err`, go to IDLE.
- DATA: each accepted byte is written to `ram[wr_ptr]`, added into an 8-bit sum, and `wr_ptr` increments. After the `N`th byte, go to CHK.
- CHK: on accept:
  - Byte equals sum: go to FILL.
  - Mismatch: set `load_err`, go to IDLE. RAM keeps its partial contents and the core stays halted.
- FILL: writes `FILL_WORD` to addresses `N`..15, one per cycle, then goes to RUN. With `N` = 16, FILL takes zero cycles and CHK goes directly to RUN.
- RUN: core running. A `SYNC_BYTE` goes to COUNT (a reload); other bytes are dropped.

Other rules:
- `load_err` clears when a `SYNC_BYTE` is accepted. It is never cleared by a successful load alone.
- Inside a frame, the value `SYNC_BYTE` is ordinary data. The loader does not resynchronise mid-frame.
- Counters:
  - `wr_ptr` is 5 bits, so the value 16 is representable.
  - `N` is compared as an 8-bit value, so 17..255 and 0 are invalid.

## Timing
Outputs by state and at reset:
- `rx_ready` = 0 in CLEAR and FILL; 1 in every other state.
- `cpu_hold` = 1 in every state except RUN.
- `load_busy` = 1 in COUNT, DATA, CHK and FILL.
- Reset values: state CLEAR, `rx_ready` 0, `cpu_hold` 1, `cpu_restart` 0, `load_busy` 0, `load_err` 0.
- A reset mid-frame abandons the frame and re-runs CLEAR (16 cycles).

RAM timing and latencies:
- RAM read is combinational: `fetch_insn` follows `fetch_addr` in the same cycle.
- A write at edge k is visible on `fetch_insn` after edge k.
- Accepting CHK at edge k gives: FILL for cycles k..k+15−N, RUN entered at edge k+16−N.
- `cpu_restart` is registered and high exactly during the first cycle in RUN. It is never asserted on the RUN→COUNT transition.
- `cpu_hold` rises in the cycle after a reload's `SYNC_BYTE` is accepted. The core may execute in the accept cycle itself; it must not fetch after that.
- Entering COUNT from RUN deasserts `cpu_hold` only when RUN is next reached, and that entry is again accompanied by `cpu_restart`.
- Backpressure: `rx_valid` held high with `rx_ready` low gives no transfer and no state change. Bytes arriving at `rx_valid`=1 on consecutive cycles in DATA are written at one per cycle.

## Structure
Shared package `lib_cpu` gains:
- `INSN`: packed struct of `OPECODE` opcode and `logic [3:0]` imm.
- `LD_STATE`: enum of CLEAR, IDLE, COUNT, DATA, CHK, FILL, RUN.
- `PROG_DEPTH` = 16.

Sub-module `prog_ram`:
- 16×8 array, no reset.
- One synchronous write port: `we`, `waddr`, `wdata`.
- One asynchronous read port: `raddr` → `rdata`.

`prog_loader` contains the FSM, counters and checksum, and instantiates `prog_ram`.

## Test plan
- **Reset:** after `rst`, 16 cycles → all addresses read `8'hF0`; `cpu_hold`=1 throughout; `rx_ready` goes 1 at cycle 16.
- **Short load:** A5, 03, 31, 52, F0, CHK=73 → addresses 0..2 = 31, 52, F0; 3..15 = F0; RUN after 13 FILL cycles; one `cpu_restart` pulse; `load_err`=0.
- **Bad checksum:** A5, 02, 11, 22, CHK=00 → `load_err`=1, state IDLE, `cpu_hold` stays 1; then a valid frame → `load_err` cleared at its sync, core released.
- **Full load:** A5, 10, bytes 00..0F, CHK=78 → no FILL cycles; RUN on the edge after CHK is accepted; address 15 = 0F.
- **Bad count / noise:** count 00 or 11 → `load_err`; junk bytes (e.g. 42) in IDLE or RUN are consumed with no state change.
- **Backpressure and reload:** `rx_valid` toggled randomly mid-frame → same RAM contents as back-to-back delivery; A5 in RUN → `cpu_hold`=1 the next cycle; `rst` mid-DATA → CLEAR and all F0.
